tone_sequencer: RTL and testbench
=================================

# tone_sequencer

Parametrised note sequencer and square-wave tone generator for the audio path. It replaces a fixed-divider note generator with a programmable note table and per-note duration, rest, pan and end-of-sequence handling, plus start/stop/loop control. Its 16-bit left/right samples feed `speaker_control` directly. Both blocks sit under the board-level speaker top.

## Interface
- `DEPTH`, 16: number of note-table entries; must be a power of two, at least 2.
- `DIV_W`, 22: width of the half-period divider field, in clk cycles.
- `DUR_W`, 8: width of the duration field, in ticks.
- `TICK_DIV`, 1_000_000: clk cycles per duration tick (10 ms at 100 MHz).
- `AMP`, 16'h2000: positive sample amplitude. The negative level is two's-complement −AMP.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock, synchronous and active-high.
- `start`  in  1  single-cycle pulse; starts playback from entry 0.
- `stop`  in  1  single-cycle pulse; aborts playback.
- `loop_en`  in  1  sampled at end of sequence; when 1, playback restarts at entry 0.
- `wr_en`  in  1  note-table write strobe.
- `wr_addr`  in  $clog2(DEPTH)  entry to write.
- `wr_data`  in  DIV_W+DUR_W+2  entry contents, fields `{pan[1:0], dur, div}`.
- `busy`  out  1  high in PLAY.
- `done`  out  1  one-cycle pulse when the sequence ends without looping.
- `cur_idx`  out  $clog2(DEPTH)  index of the entry now playing.
- `audio_left`, `audio_right`  out  16  signed samples.

## Operation
- FSM states: IDLE, LOAD, PLAY, DONE.
- IDLE: outputs silent (0). A `start` pulse moves to LOAD with idx=0.
- LOAD (1 cycle):
  - Latch entry[idx] into working registers.
  - If dur==0, the entry is an end marker: go to DONE.
  - Otherwise clear the tick and half-period counters, set the wave phase high, and go to PLAY.
- PLAY:
  - Tick counter counts 0..TICK_DIV−1. Each wrap decrements the remaining duration.
  - When remaining duration reaches 0 on a tick wrap:
    - idx==DEPTH−1: go to DONE.
    - Otherwise: idx+1, go to LOAD.
  - Half-period counter counts 0..div−1. On reaching div−1, wave phase toggles and the counter clears.
  - div==0 is a rest: phase is held and both outputs are 0 for the note's duration.
- DONE (1 cycle):
  - loop_en=1: idx=0, go to LOAD; `done` not pulsed.
  - loop_en=0: pulse `done`, go to IDLE.
- Sample value: s = phase ? AMP : −AMP.
  - audio_left = pan[1] ? s : 0.
  - audio_right = pan[0] ? s : 0.
- Control precedence:
  - `stop` in any state forces IDLE next cycle with silent outputs and no `done`.
  - `stop` and `start` in the same cycle: stop wins.
  - `start` while not IDLE is ignored.
- Table writes:
  - Accepted in every state, including mid-playback.
  - Take effect at the next LOAD of that entry. The latched working copy is never disturbed.

## Timing
- Reset values: state IDLE, busy 0, done 0, cur_idx 0, audio_left/right 0, all counters 0. Table contents are not reset.
- Reset mid-playback: IDLE on the next edge, outputs 0 from that edge.
- Start latency:
  - `start` at edge t, LOAD at t+1, PLAY at t+2.
  - First non-zero sample registered at t+2. `busy` high from t+2.
- All outputs are registered; no combinational path from inputs to outputs.
- Note length is exactly dur×TICK_DIV cycles in PLAY, plus 1 LOAD cycle per entry.
- Square-wave period is 2×div cycles. Phase does not carry across notes.
- A write at edge t is visible to a LOAD at edge t+1 or later.

## Configuration
- `TONE_SEQ_VOLUME_EN`:
  - Defined: adds input `volume[2:0]`; the sample becomes s >>> volume (arithmetic shift), so 0 = full scale and 7 = −42 dB. `volume` is sampled every cycle.
  - Undefined: no port, full-scale AMP.

## Structure
- Shared package `audio_pkg`:
  - `note_entry_t` struct {pan, dur, div}, using DIV_W/DUR_W defaults.
  - FSM state enum.
  - `SILENCE` = 16'sd0.
  - Pan constants `PAN_L`, `PAN_R`, `PAN_LR`.
- One sub-module `tone_osc`: half-period counter, phase register, and rest handling. Inputs clk, rst, clear, div; output phase.
- Note table, FSM, tick counter and sample formatting live in the top.

## Test plan
1. Reset mid-PLAY:
   - Expected: next cycle busy=0, outputs 0, cur_idx=0.
2. Single note {LR, dur=2, div=4}, TICK_DIV=10, entry1 dur=0:
   - Left/right alternate +AMP/−AMP every 4 cycles for 20 cycles.
   - Then DONE, and `done` pulses once.
3. Rest and pan sequence {L, dur=1, div=3}, {LR, dur=1, div=0}, {R, dur=1, div=5}, end marker:
   - Right is 0 during the first note.
   - Both outputs are 0 during the second note.
   - Left is 0 during the third note.
4. Full table of DEPTH non-zero entries with loop_en=1:
   - Expected: cur_idx wraps DEPTH−1 → 0 and `done` never pulses.
   - Then clear loop_en and check that `done` pulses after the next pass.
5. `start` and `stop` in the same cycle from IDLE:
   - Expected: stays IDLE.
   - Also: `start` while busy does not reset cur_idx.
6. Rewrite the currently playing entry mid-note:
   - Expected: current note is unchanged; the new values play on the next loop pass.
   - With `TONE_SEQ_VOLUME_EN`, volume=2 yields ±AMP/4.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio-path types: note table entry, sequencer states, pan codes.
// Used by tone_sequencer and its tone_osc sub-block.
package audio_pkg;

    localparam int NOTE_DIV_W = 22;
    localparam int NOTE_DUR_W = 8;

    typedef struct packed {
        logic [1:0]            pan;
        logic [NOTE_DUR_W-1:0] dur;
        logic [NOTE_DIV_W-1:0] div;
    } note_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PLAY,
        ST_DONE
    } seq_state_t;

    localparam logic signed [15:0] SILENCE = 16'sd0;

    localparam logic [1:0] PAN_L  = 2'b10;
    localparam logic [1:0] PAN_R  = 2'b01;
    localparam logic [1:0] PAN_LR = 2'b11;

endpackage

// File: rtl/tone_osc.sv
// Square-wave phase generator: half-period counter and phase register.
// div == 0 is a rest and holds the phase.
module tone_osc #(
    parameter int DIV_W = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             phase
);

    logic [DIV_W-1:0] hp_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            hp_cnt <= '0;
            phase  <= 1'b0;
        end else if (clear) begin
            hp_cnt <= '0;
            phase  <= 1'b1;
        end else if (div == '0) begin
            hp_cnt <= '0;
        end else if (hp_cnt >= div - DIV_W'(1)) begin
            hp_cnt <= '0;
            phase  <= ~phase;
        end else begin
            hp_cnt <= hp_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/tone_sequencer.sv
// Programmable note sequencer with square-wave tone output and L/R pan.
// Optional TONE_SEQ_VOLUME_EN adds a 3-bit arithmetic-shift volume input.
module tone_sequencer
    import audio_pkg::*;
#(
    parameter int          DEPTH    = 16,
    parameter int          DIV_W    = 22,
    parameter int          DUR_W    = 8,
    parameter int          TICK_DIV = 1_000_000,
    parameter logic [15:0] AMP      = 16'h2000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       loop_en,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [DIV_W+DUR_W+1:0]     wr_data,
`ifdef TONE_SEQ_VOLUME_EN
    input  logic [2:0]                 volume,
`endif
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH)-1:0]   cur_idx,
    output logic [15:0]                audio_left,
    output logic [15:0]                audio_right
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int ENT_W  = DIV_W + DUR_W + 2;
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic [ENT_W-1:0] note_tbl [DEPTH];

    seq_state_t state, state_nxt;

    logic [IDX_W-1:0]  idx;
    logic [DIV_W-1:0]  div_q;
    logic [DUR_W-1:0]  dur_left;
    logic [1:0]        pan_q;
    logic [TICK_W-1:0] tick_cnt;
    logic              done_q;

    logic [ENT_W-1:0]  entry;
    logic [DIV_W-1:0]  ent_div;
    logic [DUR_W-1:0]  ent_dur;
    logic [1:0]        ent_pan;
    logic              tick_wrap;
    logic              note_end;
    logic              phase;
    logic              osc_clear;

    logic signed [15:0] samp_full;
    logic signed [15:0] samp;

    assign entry     = note_tbl[idx];
    assign ent_div   = entry[DIV_W-1:0];
    assign ent_dur   = entry[DIV_W +: DUR_W];
    assign ent_pan   = entry[ENT_W-1 -: 2];
    assign tick_wrap = (tick_cnt == TICK_LAST);
    assign note_end  = tick_wrap && (dur_left == DUR_W'(1));
    assign osc_clear = (state == ST_LOAD);

    // Table has no reset; the working copy below isolates the playing note.
    always_ff @(posedge clk) begin
        if (wr_en)
            note_tbl[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (start) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = (ent_dur == '0) ? ST_DONE : ST_PLAY;
            ST_PLAY: begin
                if (note_end)
                    state_nxt = (idx == LAST_IDX) ? ST_DONE : ST_LOAD;
            end
            ST_DONE: state_nxt = loop_en ? ST_LOAD : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (stop)
            state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            div_q    <= '0;
            dur_left <= '0;
            pan_q    <= '0;
            tick_cnt <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state == ST_DONE) && !loop_en && !stop;
            unique case (state)
                ST_IDLE: begin
                    if (start && !stop)
                        idx <= '0;
                end
                ST_LOAD: begin
                    div_q    <= ent_div;
                    dur_left <= ent_dur;
                    pan_q    <= ent_pan;
                    tick_cnt <= '0;
                end
                ST_PLAY: begin
                    if (tick_wrap) begin
                        tick_cnt <= '0;
                        dur_left <= dur_left - DUR_W'(1);
                        if (dur_left == DUR_W'(1) && idx != LAST_IDX)
                            idx <= idx + IDX_W'(1);
                    end else begin
                        tick_cnt <= tick_cnt + TICK_W'(1);
                    end
                end
                ST_DONE: begin
                    if (loop_en)
                        idx <= '0;
                end
                default: ;
            endcase
        end
    end

    tone_osc #(
        .DIV_W (DIV_W)
    ) u_osc (
        .clk   (clk),
        .rst   (rst),
        .clear (osc_clear),
        .div   (div_q),
        .phase (phase)
    );

    assign samp_full = phase ? $signed(AMP) : -$signed(AMP);

`ifdef TONE_SEQ_VOLUME_EN
    logic [2:0] vol_q;

    always_ff @(posedge clk) begin
        if (rst)
            vol_q <= '0;
        else
            vol_q <= volume;
    end

    assign samp = samp_full >>> vol_q;
`else
    assign samp = samp_full;
`endif

    // Outputs decode registered state only; rests and non-PLAY states are silent.
    always_comb begin
        busy        = (state == ST_PLAY);
        audio_left  = SILENCE;
        audio_right = SILENCE;
        if (state == ST_PLAY && div_q != '0) begin
            if (pan_q[1])
                audio_left = samp;
            if (pan_q[0])
                audio_right = samp;
        end
    end

    assign done    = done_q;
    assign cur_idx = idx;

endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer with a short TICK_DIV.
// Expected traces are expanded note by note from a copy of the table.
module tb_tone_sequencer;
    import audio_pkg::*;

    localparam int DEPTH    = 16;
    localparam int DIV_W    = 22;
    localparam int DUR_W    = 8;
    localparam int TICK_DIV = 10;
    localparam int AMP_I    = 8192;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic        loop_en;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [2:0]  volume;
    logic        busy;
    logic        done;
    logic [3:0]  cur_idx;
    logic [15:0] audio_left;
    logic [15:0] audio_right;

    int checks = 0;
    int errors = 0;

    note_entry_t tbl [DEPTH];
    int          hk_kind;
    int          hk_idx;
    int          hk_j;
    note_entry_t hk_entry;

    always #5 clk = ~clk;

    tone_sequencer #(
        .DEPTH    (DEPTH),
        .DIV_W    (DIV_W),
        .DUR_W    (DUR_W),
        .TICK_DIV (TICK_DIV),
        .AMP      (16'h2000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .loop_en     (loop_en),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
`ifdef TONE_SEQ_VOLUME_EN
        .volume      (volume),
`endif
        .busy        (busy),
        .done        (done),
        .cur_idx     (cur_idx),
        .audio_left  (audio_left),
        .audio_right (audio_right)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cycle(string tag, logic b, logic d, int i,
                             logic [15:0] l, logic [15:0] r);
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".done"}, 32'(done), 32'(d));
        chk({tag, ".idx"}, 32'(cur_idx), 32'(i));
        chk({tag, ".left"}, 32'(audio_left), 32'(l));
        chk({tag, ".right"}, 32'(audio_right), 32'(r));
    endtask

    // Sample j cycles into a note: phase high for the first div cycles.
    function automatic logic [15:0] samp(note_entry_t e, int j, logic side);
        int s;
        if (e.div == '0 || !side)
            return 16'h0;
        s = (((j / int'(e.div)) % 2) == 0) ? AMP_I : -AMP_I;
`ifdef TONE_SEQ_VOLUME_EN
        s = s >>> volume;
`endif
        return 16'(s);
    endfunction

    task automatic write_entry(int a, logic [1:0] pan, int dur, int dv);
        note_entry_t e;
        e.pan   = pan;
        e.dur   = DUR_W'(dur);
        e.div   = DIV_W'(dv);
        wr_en   = 1'b1;
        wr_addr = 4'(a);
        wr_data = e;
        tick();
        wr_en   = 1'b0;
        tbl[a]  = e;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Walks one pass from entry 0; returns while the DUT sits in DONE.
    task automatic play_pass(output bit aborted);
        int          idx;
        note_entry_t e;
        bit          hit;
        idx     = 0;
        aborted = 1'b0;
        forever begin
            chk_cycle("load", 1'b0, 1'b0, idx, 16'h0, 16'h0);
            e = tbl[idx];
            tick();
            if (e.dur == '0) begin
                chk_cycle("end_mark", 1'b0, 1'b0, idx, 16'h0, 16'h0);
                return;
            end
            for (int j = 0; j < int'(e.dur) * TICK_DIV; j++) begin
                chk_cycle("play", 1'b1, 1'b0, idx,
                          samp(e, j, e.pan[1]), samp(e, j, e.pan[0]));
                hit = (hk_kind != 0) && (idx == hk_idx) && (j == hk_j);
                if (hit) begin
                    case (hk_kind)
                        1: begin
                            wr_en   = 1'b1;
                            wr_addr = 4'(idx);
                            wr_data = hk_entry;
                        end
                        2: start = 1'b1;
                        default: stop = 1'b1;
                    endcase
                end
                tick();
                wr_en = 1'b0;
                start = 1'b0;
                stop  = 1'b0;
                if (hit) begin
                    if (hk_kind == 1)
                        tbl[idx] = hk_entry;
                    if (hk_kind == 3) begin
                        hk_kind = 0;
                        chk("stop.busy", 32'(busy), 32'd0);
                        chk("stop.done", 32'(done), 32'd0);
                        chk("stop.left", 32'(audio_left), 32'd0);
                        chk("stop.right", 32'(audio_right), 32'd0);
                        aborted = 1'b1;
                        return;
                    end
                    hk_kind = 0;
                end
            end
            if (idx == DEPTH - 1) begin
                chk_cycle("seq_end", 1'b0, 1'b0, idx, 16'h0, 16'h0);
                return;
            end
            idx++;
        end
    endtask

    task automatic finish_check();
        tick();
        chk("done_pulse", 32'(done), 32'd1);
        chk("idle.busy", 32'(busy), 32'd0);
        chk("idle.left", 32'(audio_left), 32'd0);
        chk("idle.right", 32'(audio_right), 32'd0);
        tick();
        chk("done_once", 32'(done), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ab;
        int n;
        rst     = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        loop_en = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        volume  = '0;
        hk_kind = 0;
        hk_idx  = 0;
        hk_j    = 0;
        hk_entry = '0;
        tick();
        tick();
        rst = 1'b0;
        chk_cycle("reset", 1'b0, 1'b0, 0, 16'h0, 16'h0);

        // Single note then end marker.
        write_entry(0, PAN_LR, 2, 4);
        write_entry(1, 2'b00, 0, 0);
        start_pulse();
        play_pass(ab);
        finish_check();

        // Pan and rest sequence.
        write_entry(0, PAN_L, 1, 3);
        write_entry(1, PAN_LR, 1, 0);
        write_entry(2, PAN_R, 1, 5);
        write_entry(3, 2'b00, 0, 0);
        start_pulse();
        play_pass(ab);
        finish_check();

        // start and stop together from IDLE.
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        repeat (3) begin
            chk("startstop.busy", 32'(busy), 32'd0);
            chk("startstop.left", 32'(audio_left), 32'd0);
            tick();
        end

        // start while busy is ignored.
        hk_kind = 2;
        hk_idx  = 1;
        hk_j    = 3;
        start_pulse();
        play_pass(ab);
        finish_check();

        // stop mid-note.
        hk_kind = 3;
        hk_idx  = 2;
        hk_j    = 2;
        start_pulse();
        play_pass(ab);
        tick();
        chk("stop.nodone", 32'(done), 32'd0);
        chk("stop.stays", 32'(busy), 32'd0);

        // Reset mid-PLAY.
        start_pulse();
        tick();
        tick();
        chk("pre_rst.busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_cycle("rst_mid", 1'b0, 1'b0, 0, 16'h0, 16'h0);
        tick();
        chk("rst_mid.after", 32'(busy), 32'd0);

        // Full table with looping, then a final pass without.
        for (int i = 0; i < DEPTH; i++)
            write_entry(i, 2'($urandom_range(0, 3)),
                        int'($urandom_range(1, 2)), int'($urandom_range(0, 6)));
        loop_en = 1'b1;
        start_pulse();
        play_pass(ab);
        tick();
        loop_en = 1'b0;
        play_pass(ab);
        finish_check();

        // Rewrite the playing entry mid-note.
`ifdef TONE_SEQ_VOLUME_EN
        volume = 3'd2;
`endif
        for (int i = 0; i < 4; i++)
            write_entry(i, 2'($urandom_range(1, 3)), 2,
                        int'($urandom_range(1, 6)));
        write_entry(4, 2'b00, 0, 0);
        hk_kind      = 1;
        hk_idx       = 1;
        hk_j         = 5;
        hk_entry.pan = PAN_LR;
        hk_entry.dur = DUR_W'(1);
        hk_entry.div = DIV_W'(2);
        loop_en = 1'b1;
        start_pulse();
        play_pass(ab);
        tick();
        loop_en = 1'b0;
        play_pass(ab);
        finish_check();

        // Random short sequences.
        repeat (3) begin
            n = int'($urandom_range(1, 5));
            volume = 3'($urandom_range(0, 7));
            for (int i = 0; i < n; i++)
                write_entry(i, 2'($urandom_range(0, 3)),
                            int'($urandom_range(1, 3)), int'($urandom_range(0, 9)));
            write_entry(n, 2'($urandom_range(0, 3)), 0,
                        int'($urandom_range(0, 9)));
            start_pulse();
            play_pass(ab);
            finish_check();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
